// File: rtl/axicb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axicb_pkg
//  Purpose  : Shared types and helpers for the crossbar merge stage.
//             - merge_state_t : IDLE / HOLD / LOCKED arbitration states
//             - grant_width() : index width for an N-way selector (min 1)
//  Revision : 1.0 - initial release
// ============================================================================
package axicb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,  // free to arbitrate
    ST_HOLD   = 2'd1,  // first beat offered but stalled; grant frozen
    ST_LOCKED = 2'd2   // inside a packet; grant held until last beat
  } merge_state_t;

  function automatic int grant_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axicb_round_robin.sv
`default_nettype none
// ============================================================================
//  Module   : axicb_round_robin
//  Purpose  : Combinational masked priority encoder. Returns the first
//             asserted request at or above i_ptr, wrapping past NB_REQ-1.
//  Ports    : i_req     - request vector
//             i_ptr     - priority pointer (highest-priority index)
//             o_gnt_oh  - one-hot grant (all zero when no request)
//             o_gnt_idx - binary grant index (0 when no request)
//  Revision : 1.0 - initial release
// ============================================================================
module axicb_round_robin #(
  parameter int NB_REQ = 4,
  parameter int IDX_W  = 2
) (
  input  logic [NB_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]  i_ptr,
  output logic [NB_REQ-1:0] o_gnt_oh,
  output logic [IDX_W-1:0]  o_gnt_idx
);

  // w_cand[i] is the requester index examined at priority rank i.
  logic [IDX_W-1:0] w_cand [NB_REQ];

  generate
    for (genvar gi = 0; gi < NB_REQ; gi++) begin : g_cand
      logic [IDX_W:0] w_sum;
      assign w_sum       = {1'b0, i_ptr} + (IDX_W+1)'(gi);
      assign w_cand[gi]  = (w_sum >= (IDX_W+1)'(NB_REQ))
                         ? IDX_W'(w_sum - (IDX_W+1)'(NB_REQ))
                         : w_sum[IDX_W-1:0];
    end
  endgenerate

  always_comb begin
    o_gnt_idx = '0;
    // Walk from lowest priority to highest so the highest-priority hit wins.
    for (int i = NB_REQ - 1; i >= 0; i--) begin
      if (i_req[w_cand[i]]) o_gnt_idx = w_cand[i];
    end
    o_gnt_oh = '0;
    if (|i_req) o_gnt_oh[o_gnt_idx] = 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/axicb_rr_merge.sv
`default_nettype none
// ============================================================================
//  Module   : axicb_rr_merge
//  Purpose  : N-to-1 round-robin merge in front of the crossbar pipeline
//             stage. Grant is locked from first beat to last beat so bursts
//             never interleave. Output path is combinational.
//  Ports    : aclk, areset (async), srst (sync) - clock and resets
//             i_valid/i_ready/i_data/i_last     - NB_INPUT requesters
//             o_valid/o_ready/o_data/o_last     - merged stream
//             o_grant                           - selected requester index
//  Revision : 1.0 - initial release
// ============================================================================
module axicb_rr_merge
  import axicb_pkg::*;
#(
  parameter int NB_INPUT   = 4,
  parameter int DATA_BUS_W = 8,
  parameter int USE_LAST   = 1,
  localparam int GW        = grant_width(NB_INPUT)
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic                           srst,
  input  logic [NB_INPUT-1:0]            i_valid,
  output logic [NB_INPUT-1:0]            i_ready,
  input  logic [NB_INPUT*DATA_BUS_W-1:0] i_data,
  input  logic [NB_INPUT-1:0]            i_last,
  output logic                           o_valid,
  input  logic                           o_ready,
  output logic [DATA_BUS_W-1:0]          o_data,
  output logic                           o_last,
  output logic [GW-1:0]                  o_grant
);

  merge_state_t        r_state;
  logic [GW-1:0]       r_ptr;
  logic [GW-1:0]       r_gnt;

  logic [NB_INPUT-1:0] w_rr_oh;
  logic [GW-1:0]       w_rr_idx;
  logic [NB_INPUT-1:0] w_sel_oh;
  logic [GW-1:0]       w_sel;
  logic [GW-1:0]       w_ptr_nxt;
  logic                w_idle;
  logic                w_any;
  logic                w_quiet;
  logic                w_valid;
  logic                w_last;
  logic                w_accept;

  axicb_round_robin #(
    .NB_REQ (NB_INPUT),
    .IDX_W  (GW)
  ) u_rr (
    .i_req     (i_valid),
    .i_ptr     (r_ptr),
    .o_gnt_oh  (w_rr_oh),
    .o_gnt_idx (w_rr_idx)
  );

  assign w_idle  = (r_state == ST_IDLE);
  assign w_any   = |i_valid;
  assign w_sel   = w_idle ? w_rr_idx : r_gnt;
  // Outputs read as zero while in reset or idle with nothing to send.
  assign w_quiet = areset | (w_idle & ~w_any);

  always_comb begin
    w_sel_oh = '0;
    if (w_idle) w_sel_oh = w_rr_oh;
    else        w_sel_oh[r_gnt] = 1'b1;
  end

  assign w_valid  = ~areset & (w_idle ? w_any : i_valid[r_gnt]);
  assign w_last   = (USE_LAST != 0) ? i_last[w_sel] : 1'b1;
  assign w_accept = w_valid & o_ready;

  assign o_valid  = w_valid;
  assign i_ready  = w_sel_oh & {NB_INPUT{w_accept}};
  assign o_data   = w_quiet ? '0   : i_data[w_sel*DATA_BUS_W +: DATA_BUS_W];
  assign o_last   = w_quiet ? 1'b0 : w_last;
  assign o_grant  = w_sel;

  assign w_ptr_nxt = (w_sel == GW'(NB_INPUT - 1)) ? '0 : w_sel + 1'b1;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
    end else if (srst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
    end else begin
      if (w_accept) begin
        if (w_last) begin
          // Packet complete: release and rotate priority past the winner.
          r_state <= ST_IDLE;
          r_ptr   <= w_ptr_nxt;
        end else begin
          r_state <= ST_LOCKED;
          r_gnt   <= w_sel;
        end
      end else if (w_idle && w_any) begin
        // Stalled first beat: freeze the choice so it cannot be preempted.
        r_state <= ST_HOLD;
        r_gnt   <= w_sel;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axicb_rr_merge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axicb_rr_merge
//  Purpose  : Directed self-checking bench for axicb_rr_merge (4 x 8 bits).
//             Inputs change on the falling edge; outputs are sampled 1 ns
//             later, well before the next rising edge commits state.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axicb_rr_merge;

  localparam int NB = 4;
  localparam int DW = 8;
  localparam int GW = 2;

  logic              aclk = 1'b0;
  logic              areset;
  logic              srst;
  logic [NB-1:0]     i_valid;
  logic [NB-1:0]     i_ready;
  logic [NB*DW-1:0]  i_data;
  logic [NB-1:0]     i_last;
  logic              o_valid;
  logic              o_ready;
  logic [DW-1:0]     o_data;
  logic              o_last;
  logic [GW-1:0]     o_grant;

  int checks   = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  axicb_rr_merge #(
    .NB_INPUT   (NB),
    .DATA_BUS_W (DW),
    .USE_LAST   (1)
  ) dut (
    .aclk    (aclk),
    .areset  (areset),
    .srst    (srst),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_data  (i_data),
    .i_last  (i_last),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_last  (o_last),
    .o_grant (o_grant)
  );

  // Requester k always presents payload (k+1)*0x11.
  function automatic logic [DW-1:0] pay(input int k);
    return DW'((k + 1) * 17);
  endfunction

  task automatic do_reset();
    @(negedge aclk);
    areset  = 1'b1;
    srst    = 1'b0;
    i_valid = '0;
    i_last  = '0;
    o_ready = 1'b0;
    @(negedge aclk);
    areset  = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge aclk);
    areset  = 1'b1;
    i_valid = 4'b1111;
    i_last  = 4'b1111;
    o_ready = 1'b1;
    #1;
    checks++;
    if (o_valid !== 1'b0) begin
      failures++; $display("FAIL reset_o_valid got=%b exp=0", o_valid);
    end
    checks++;
    if (i_ready !== 4'b0000) begin
      failures++; $display("FAIL reset_i_ready got=%b exp=0000", i_ready);
    end
    checks++;
    if ({o_grant, o_data, o_last} !== '0) begin
      failures++; $display("FAIL reset_outputs got grant=%0d data=%h last=%b exp all 0", o_grant, o_data, o_last);
    end
    // Release with everyone requesting: requester 0 first, then 1.
    @(negedge aclk);
    areset = 1'b0;
    #1;
    checks++;
    if (o_grant !== 2'd0 || i_ready !== 4'b0001 || o_data !== pay(0) || o_last !== 1'b1) begin
      failures++; $display("FAIL reset_first_grant got grant=%0d rdy=%b data=%h last=%b exp 0/0001/%h/1", o_grant, i_ready, o_data, o_last, pay(0));
    end
    @(negedge aclk);
    #1;
    checks++;
    if (o_grant !== 2'd1) begin
      failures++; $display("FAIL reset_ptr_advance got=%0d exp=1", o_grant);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    @(negedge aclk);
    i_valid = 4'b1111;
    i_last  = 4'b1111;
    o_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) @(negedge aclk);
      #1;
      checks++;
      if (o_grant !== GW'(i % NB) || i_ready !== NB'(1 << (i % NB)) || o_valid !== 1'b1) begin
        failures++; $display("FAIL fair_cycle%0d got grant=%0d rdy=%b vld=%b exp grant=%0d", i, o_grant, i_ready, o_valid, i % NB);
      end
    end
  endtask

  task automatic test_burst_lock();
    do_reset();
    // One packet from requester 0 alone moves the pointer to 1.
    @(negedge aclk);
    i_valid = 4'b0001;
    i_last  = 4'b1111;
    o_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      @(negedge aclk);
      i_valid = 4'b1111;
      i_last  = (b == 3) ? 4'b1111 : 4'b1101;
      #1;
      checks++;
      if (o_grant !== 2'd1 || i_ready !== 4'b0010 || o_data !== pay(1) || o_last !== (b == 3)) begin
        failures++; $display("FAIL burst_beat%0d got grant=%0d rdy=%b data=%h last=%b exp 1/0010/%h/%0d", b, o_grant, i_ready, o_data, o_last, pay(1), b == 3);
      end
    end
    @(negedge aclk);
    #1;
    checks++;
    if (o_grant !== 2'd2 || i_ready !== 4'b0100) begin
      failures++; $display("FAIL burst_next got grant=%0d rdy=%b exp 2/0100", o_grant, i_ready);
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      i_valid = (c >= 2) ? 4'b0101 : 4'b0100;
      i_last  = 4'b1111;
      o_ready = 1'b0;
      #1;
      checks++;
      if (o_grant !== 2'd2 || o_data !== pay(2) || o_valid !== 1'b1 || i_ready !== 4'b0000) begin
        failures++; $display("FAIL stall_cycle%0d got grant=%0d data=%h vld=%b rdy=%b exp 2/%h/1/0000", c, o_grant, o_data, o_valid, i_ready, pay(2));
      end
    end
    @(negedge aclk);
    o_ready = 1'b1;
    #1;
    checks++;
    if (o_grant !== 2'd2 || i_ready !== 4'b0100) begin
      failures++; $display("FAIL stall_accept got grant=%0d rdy=%b exp 2/0100", o_grant, i_ready);
    end
    @(negedge aclk);
    #1;
    checks++;
    if (o_grant !== 2'd0 || i_ready !== 4'b0001) begin
      failures++; $display("FAIL stall_next got grant=%0d rdy=%b exp 0/0001", o_grant, i_ready);
    end
  endtask

  task automatic test_gap();
    do_reset();
    @(negedge aclk);
    i_valid = 4'b1000;
    i_last  = 4'b0000;
    o_ready = 1'b1;
    #1;
    checks++;
    if (o_grant !== 2'd3 || i_ready !== 4'b1000) begin
      failures++; $display("FAIL gap_first got grant=%0d rdy=%b exp 3/1000", o_grant, i_ready);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      i_valid = 4'b0001;
      i_last  = 4'b0001;
      #1;
      checks++;
      if (o_valid !== 1'b0 || i_ready !== 4'b0000 || o_grant !== 2'd3) begin
        failures++; $display("FAIL gap_cycle%0d got vld=%b rdy=%b grant=%0d exp 0/0000/3", c, o_valid, i_ready, o_grant);
      end
    end
    @(negedge aclk);
    i_valid = 4'b1001;
    i_last  = 4'b1000;
    #1;
    checks++;
    if (o_valid !== 1'b1 || o_grant !== 2'd3 || i_ready !== 4'b1000 || o_last !== 1'b1) begin
      failures++; $display("FAIL gap_resume got vld=%b grant=%0d rdy=%b last=%b exp 1/3/1000/1", o_valid, o_grant, i_ready, o_last);
    end
    @(negedge aclk);
    #1;
    checks++;
    if (o_grant !== 2'd0 || i_ready !== 4'b0001) begin
      failures++; $display("FAIL gap_next got grant=%0d rdy=%b exp 0/0001", o_grant, i_ready);
    end
  endtask

  task automatic test_srst();
    do_reset();
    @(negedge aclk);
    i_valid = 4'b0100;
    i_last  = 4'b0000;
    o_ready = 1'b1;
    @(negedge aclk);
    i_valid = 4'b0110;
    o_ready = 1'b0;
    srst    = 1'b1;
    #1;
    checks++;
    if (o_grant !== 2'd2 || o_valid !== 1'b1) begin
      failures++; $display("FAIL srst_locked got grant=%0d vld=%b exp 2/1", o_grant, o_valid);
    end
    @(negedge aclk);
    srst    = 1'b0;
    o_ready = 1'b1;
    #1;
    checks++;
    if (o_grant !== 2'd1 || i_ready !== 4'b0010) begin
      failures++; $display("FAIL srst_regrant got grant=%0d rdy=%b exp 1/0010", o_grant, i_ready);
    end
  endtask

  initial begin
    areset  = 1'b1;
    srst    = 1'b0;
    i_valid = '0;
    i_last  = '0;
    o_ready = 1'b0;
    for (int k = 0; k < NB; k++) i_data[k*DW +: DW] = pay(k);

    test_reset();
    test_fairness();
    test_burst_lock();
    test_stall();
    test_gap();
    test_srst();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
